// File: rtl/lane_deskew_pkg.sv
// Shared definitions for the lane deskew buffer: default geometry and output-state encoding.
// Optional feature macro used by this block: LANE_DESKEW_OVF_EN (sticky per-lane overflow flags).
package lane_deskew_pkg;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_NUB   = 4;
    localparam int DEF_DEPTH = 4;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/lane_deskew_if.sv
// Lane-side input bundle and aligned-word output handshake of the deskew buffer.
interface lane_deskew_if
    import lane_deskew_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NUB   = DEF_NUB
);
    logic                   flush;
    logic [NUB-1:0]         in_valid;
    logic [WIDTH*NUB-1:0]   in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH*NUB-1:0]   out_data;
    logic [NUB-1:0]         overflow;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  out_valid, out_data, overflow
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output out_valid, out_data, overflow
    );
endinterface

// File: rtl/deskew_lane_fifo.sv
// Single-lane FIFO with wrap-bit pointers; a push into a full FIFO only lands if the same edge pops.
module deskew_lane_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

    // Storage carries no reset: contents are only observed behind a valid pointer.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
    end

    assign dout = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/lane_deskew.sv
// Multi-lane deskew buffer: per-lane FIFOs feeding one output register that loads all lanes together.
// Define LANE_DESKEW_OVF_EN to build the sticky per-lane overflow flags; otherwise overflow reads 0.
module lane_deskew
    import lane_deskew_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NUB   = DEF_NUB,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    lane_deskew_if.slave  bus
);
    logic [NUB-1:0]       fifo_empty;
    logic [NUB-1:0]       push;
    logic [WIDTH*NUB-1:0] head_word;
    logic                 all_ready;
    logic                 pop;

    out_state_t           state_reg;
    logic                 out_valid_reg;
    logic [WIDTH*NUB-1:0] out_data_reg;

`ifdef LANE_DESKEW_OVF_EN
    logic [NUB-1:0]       fifo_full;
    logic [NUB-1:0]       drop;
    logic [NUB-1:0]       overflow_reg;
`endif

    assign all_ready = ~|fifo_empty;
    // A single pop strobe is broadcast so that lanes can never slip relative to each other.
    assign pop = !bus.flush && all_ready && ((state_reg == OUT_EMPTY) || bus.out_ready);

    generate
        for (genvar gi = 0; gi < NUB; gi++) begin : g_lane
            assign push[gi] = bus.in_valid[gi] && !bus.flush;

            deskew_lane_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst_n (rst_n),
                .flush (bus.flush),
                .push  (push[gi]),
                .pop   (pop),
                .din   (bus.in_data[gi*WIDTH +: WIDTH]),
                .dout  (head_word[gi*WIDTH +: WIDTH]),
                .empty (fifo_empty[gi]),
`ifdef LANE_DESKEW_OVF_EN
                .full  (fifo_full[gi])
`else
                .full  ()
`endif
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= OUT_EMPTY;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (bus.flush) begin
            state_reg     <= OUT_EMPTY;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                OUT_EMPTY: begin
                    if (pop) begin
                        state_reg     <= OUT_FULL;
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= head_word;
                    end
                end
                OUT_FULL: begin
                    if (pop) begin
                        out_data_reg  <= head_word;
                    end else if (bus.out_ready) begin
                        state_reg     <= OUT_EMPTY;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= OUT_EMPTY;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;

`ifdef LANE_DESKEW_OVF_EN
    // A word is lost only when its lane is full and the shared pop does not free a slot.
    assign drop = push & fifo_full & ~{NUB{pop}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= '0;
        end else if (bus.flush) begin
            overflow_reg <= '0;
        end else begin
            overflow_reg <= overflow_reg | drop;
        end
    end

    assign bus.overflow = overflow_reg;
`else
    assign bus.overflow = '0;
`endif

endmodule

// File: tb/tb_lane_deskew.sv
// Self-checking bench for lane_deskew: directed scenarios plus random traffic against a queue-based model.
module tb_lane_deskew;
    localparam int WIDTH = 3;
    localparam int NUB   = 4;
    localparam int DEPTH = 4;
    localparam int W     = WIDTH * NUB;

    logic clk;
    logic rst_n;

    lane_deskew_if #(.WIDTH(WIDTH), .NUB(NUB)) bus ();

    lane_deskew #(
        .WIDTH (WIDTH),
        .NUB   (NUB),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int n_xfer;
    int pulses;

    // Reference model: one queue per lane plus the presented word.
    logic [WIDTH-1:0] mq [NUB][$];
    logic             m_valid;
    logic [W-1:0]     m_data;
    logic [NUB-1:0]   m_ovf;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NUB-1:0] exp_ovf();
`ifdef LANE_DESKEW_OVF_EN
        return m_ovf;
`else
        return '0;
`endif
    endfunction

    task automatic model_clear();
        for (int j = 0; j < NUB; j++) mq[j].delete();
        m_valid = 1'b0;
        m_ovf   = '0;
    endtask

    task automatic model_step(input logic [NUB-1:0] iv, input logic [W-1:0] id,
                              input logic rdy, input logic fl);
        bit take;
        if (fl) begin
            model_clear();
            return;
        end
        if (m_valid && rdy) begin
            $display("xfer %0d data=%03h", n_xfer, m_data);
            n_xfer++;
        end
        take = 1'b1;
        for (int j = 0; j < NUB; j++) if (mq[j].size() == 0) take = 1'b0;
        if (m_valid && !rdy) take = 1'b0;
        if (take) begin
            for (int j = 0; j < NUB; j++) m_data[j*WIDTH +: WIDTH] = mq[j].pop_front();
            m_valid = 1'b1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        for (int j = 0; j < NUB; j++) begin
            if (iv[j]) begin
                if (mq[j].size() < DEPTH) mq[j].push_back(id[j*WIDTH +: WIDTH]);
                else m_ovf[j] = 1'b1;
            end
        end
    endtask

    // Called at a falling edge: drive, advance the model, clock once, then compare at the next falling edge.
    task automatic cycle(input logic [NUB-1:0] iv, input logic [W-1:0] id,
                         input logic rdy, input logic fl);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = rdy;
        bus.flush     = fl;
        model_step(iv, id, rdy, fl);
        @(posedge clk);
        @(negedge clk);
        check_val("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        check_val("out_data", {20'd0, bus.out_data}, {20'd0, m_data});
        check_val("overflow", {28'd0, bus.overflow}, {28'd0, exp_ovf()});
        if (bus.out_valid) pulses++;
    endtask

    function automatic logic [W-1:0] rep(input int v);
        logic [W-1:0] r;
        for (int j = 0; j < NUB; j++) r[j*WIDTH +: WIDTH] = WIDTH'(v + j);
        return r;
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_xfer   = 0;
        m_data   = '0;
        model_clear();
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("rst_data", {20'd0, bus.out_data}, 32'd0);
        check_val("rst_ovf", {28'd0, bus.overflow}, 32'd0);
        rst_n = 1'b1;

        // Aligned word: lanes 3..0 = 3,2,1,0
        pulses = 0;
        cycle(4'hF, 12'h688, 1'b1, 1'b0);
        cycle(4'h0, 12'h000, 1'b1, 1'b0);
        check_val("aligned_data", {20'd0, bus.out_data}, 32'h688);
        cycle(4'h0, 12'h000, 1'b1, 1'b0);
        check_val("aligned_pulses", pulses, 1);

        // Skewed arrival: lane j valid only in cycle j
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            logic [NUB-1:0] iv;
            iv = (c < NUB) ? NUB'(1 << c) : '0;
            cycle(iv, {3'd4, 3'd7, 3'd6, 3'd5}, 1'b1, 1'b0);
        end
        check_val("skew_pulses", pulses, 1);
        check_val("skew_data", {20'd0, bus.out_data}, {20'd0, 12'o4765});

        // Backpressure: five words fit, the sixth is dropped
        for (int k = 0; k < 5; k++) cycle(4'hF, rep(k), 1'b0, 1'b0);
        check_val("bp_ovf5", {28'd0, bus.overflow}, 32'd0);
        check_val("bp_hold", {20'd0, bus.out_data}, {20'd0, rep(0)});
        cycle(4'hF, rep(5), 1'b0, 1'b0);
        check_val("bp_hold6", {20'd0, bus.out_data}, {20'd0, rep(0)});
        for (int k = 0; k < 6; k++) cycle(4'h0, '0, 1'b1, 1'b0);

        // Flush with words buffered and overflow set
        for (int k = 0; k < 3; k++) cycle(4'hF, rep(k + 2), 1'b0, 1'b0);
        cycle(4'hF, rep(7), 1'b0, 1'b1);
        check_val("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("flush_ovf", {28'd0, bus.overflow}, 32'd0);
        cycle(4'hF, rep(3), 1'b1, 1'b0);
        cycle(4'h0, '0, 1'b1, 1'b0);
        check_val("flush_fresh", {20'd0, bus.out_data}, {20'd0, rep(3)});

        // Full FIFOs and full output register, popping while pushing
        cycle(4'h0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cycle(4'hF, rep(k + 1), 1'b0, 1'b0);
        cycle(4'hF, rep(6), 1'b1, 1'b0);
        check_val("fullpop_ovf", {28'd0, bus.overflow}, 32'd0);
        for (int k = 0; k < 7; k++) cycle(4'h0, '0, 1'b1, 1'b0);

        // Asynchronous reset while a word is presented
        cycle(4'hF, rep(2), 1'b0, 1'b0);
        cycle(4'h0, '0, 1'b0, 1'b0);
        check_val("prereset_valid", {31'd0, bus.out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("areset_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("areset_data", {20'd0, bus.out_data}, 32'd0);
        model_clear();
        m_data = '0;
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 4; k++) cycle(4'h0, '0, 1'b1, 1'b0);
        check_val("no_stale", pulses, 0);

        // Random traffic with bursts of backpressure and rare flushes
        for (int c = 0; c < 600; c++) begin
            logic [NUB-1:0] iv;
            logic [W-1:0]   id;
            logic           rdy;
            for (int j = 0; j < NUB; j++) iv[j] = ($urandom_range(9) < 7);
            id  = W'($urandom);
            rdy = ((c / 50) % 2 == 0) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            cycle(iv, id, rdy, ($urandom_range(99) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
